// File: rtl/dac_slew_stage.sv
// rtl/dac_slew_stage.sv - slew-rate limited, clamped DAC setpoint stage driving a two-lane sample stream.
// Optional lane encoding: define DAC_SLEW_OFFSET_BINARY_EN for offset-binary lanes (default two's complement).
module dac_slew_stage #(
  parameter int DAC_DATA_WIDTH   = 14,
  parameter int AXIS_TDATA_WIDTH = 32
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              en_i,
  input  logic signed [DAC_DATA_WIDTH-1:0]  target_i,
  input  logic                              target_valid_i,
  input  logic        [DAC_DATA_WIDTH-1:0]  step_i,
  input  logic signed [DAC_DATA_WIDTH-1:0]  lim_lo_i,
  input  logic signed [DAC_DATA_WIDTH-1:0]  lim_hi_i,
  output logic        [AXIS_TDATA_WIDTH-1:0] M_AXIS_tdata_o,
  output logic                              M_AXIS_tvalid_o,
  input  logic                              M_AXIS_tready_i,
  output logic        [3:0]                 status_o
);

  localparam int DW     = DAC_DATA_WIDTH;
  localparam int XW     = DAC_DATA_WIDTH + 1;
  localparam int LANE_W = AXIS_TDATA_WIDTH / 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RAMP,
    S_HOLD,
    S_DOWN,
    S_FAULT
  } state_e;

  state_e                state_q, state_d;
  logic signed [DW-1:0]  out_q, out_d;
  logic signed [DW-1:0]  target_q, target_d;
  logic                  clamped_q, clamped_d;
  logic                  tvalid_q;

  logic [1:0]            rst_sync_q;
  logic                  rst_int_n;

  logic                  lim_bad;
  logic                  load_ok;
  logic                  beat;
  logic signed [DW-1:0]  tgt_clamped;
  logic                  tgt_was_clamped;

  logic signed [DW-1:0]  aim;
  logic        [XW-1:0]  diff;
  logic        [XW-1:0]  mag;
  logic                  slew_done;
  logic signed [DW-1:0]  slew_out;

  logic [LANE_W-1:0]     lane;

  // Assert passes straight through; release is delayed two clocks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_int_n = rst_sync_q[1];

  assign lim_bad = (lim_lo_i > lim_hi_i);
  assign load_ok = target_valid_i && en_i && !lim_bad;
  assign beat    = tvalid_q && M_AXIS_tready_i;

  always_comb begin
    tgt_clamped = target_i;
    if (target_i < lim_lo_i) begin
      tgt_clamped = lim_lo_i;
    end else if (target_i > lim_hi_i) begin
      tgt_clamped = lim_hi_i;
    end
    tgt_was_clamped = (tgt_clamped != target_i);
  end

  // One slew step toward aim; the 15-bit difference cannot wrap for 14-bit operands.
  always_comb begin
    aim       = (state_q == S_DOWN) ? '0 : target_q;
    diff      = {aim[DW-1], aim} - {out_q[DW-1], out_q};
    mag       = diff[XW-1] ? (-diff) : diff;
    slew_done = (step_i == '0) || (mag <= {1'b0, step_i});
    if (slew_done) begin
      slew_out = aim;
    end else if (diff[XW-1]) begin
      slew_out = out_q - step_i;
    end else begin
      slew_out = out_q + step_i;
    end
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q   <= S_IDLE;
      out_q     <= '0;
      target_q  <= '0;
      clamped_q <= 1'b0;
      tvalid_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      out_q     <= out_d;
      target_q  <= target_d;
      clamped_q <= clamped_d;
      tvalid_q  <= 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    out_d     = out_q;
    target_d  = target_q;
    clamped_d = clamped_q;
    if (lim_bad) begin
      state_d = S_FAULT;
      out_d   = '0;
    end else begin
      case (state_q)
        S_IDLE, S_FAULT: begin
          out_d = '0;
          if (load_ok) begin
            target_d  = tgt_clamped;
            clamped_d = tgt_was_clamped;
            state_d   = S_RAMP;
          end
        end
        S_RAMP, S_HOLD: begin
          // Enable fall wins over a coincident load; a load holds the output for this beat.
          if (!en_i) begin
            state_d = S_DOWN;
          end else if (target_valid_i) begin
            target_d  = tgt_clamped;
            clamped_d = tgt_was_clamped;
            state_d   = S_RAMP;
          end else if (state_q == S_RAMP && beat) begin
            out_d = slew_out;
            if (slew_done) begin
              state_d = S_HOLD;
            end
          end
        end
        S_DOWN: begin
          if (beat) begin
            out_d = slew_out;
            if (slew_done) begin
              state_d = S_IDLE;
            end
          end
        end
        default: begin
          state_d = S_IDLE;
          out_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
`ifdef DAC_SLEW_OFFSET_BINARY_EN
    lane = {{(LANE_W-DW){1'b0}}, ~out_q[DW-1], out_q[DW-2:0]};
`else
    lane = {{(LANE_W-DW){out_q[DW-1]}}, out_q};
`endif
    M_AXIS_tdata_o  = {lane, lane};
    M_AXIS_tvalid_o = tvalid_q;
    status_o        = {(state_q == S_FAULT),
                       clamped_q,
                       (state_q == S_RAMP) || (state_q == S_DOWN),
                       (state_q == S_HOLD) && (out_q == target_q)};
  end

endmodule

// File: tb/tb_dac_slew_stage.sv
// tb/tb_dac_slew_stage.sv - directed and randomized self-checking bench for dac_slew_stage.
module tb_dac_slew_stage;

  logic               clk;
  logic               rst_n;
  logic               en_i;
  logic signed [13:0] target_i;
  logic               target_valid_i;
  logic        [13:0] step_i;
  logic signed [13:0] lim_lo_i;
  logic signed [13:0] lim_hi_i;
  logic        [31:0] M_AXIS_tdata_o;
  logic               M_AXIS_tvalid_o;
  logic               M_AXIS_tready_i;
  logic        [3:0]  status_o;

  int n_cmp = 0;
  int n_err = 0;

  // Reference state: output value, latched target, clamp flag, and whether the ramp has landed.
  int m_out, m_tgt, m_step;
  bit m_clamped, m_settled;

  dac_slew_stage #(.DAC_DATA_WIDTH(14), .AXIS_TDATA_WIDTH(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .en_i           (en_i),
    .target_i       (target_i),
    .target_valid_i (target_valid_i),
    .step_i         (step_i),
    .lim_lo_i       (lim_lo_i),
    .lim_hi_i       (lim_hi_i),
    .M_AXIS_tdata_o (M_AXIS_tdata_o),
    .M_AXIS_tvalid_o(M_AXIS_tvalid_o),
    .M_AXIS_tready_i(M_AXIS_tready_i),
    .status_o       (status_o)
  );

  initial clk = 1'b0;
  always #4 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] exp_tdata(input int v);
    logic [13:0] s;
    logic [15:0] lane;
    s = v[13:0];
`ifdef DAC_SLEW_OFFSET_BINARY_EN
    lane = {2'b00, ~s[13], s[12:0]};
`else
    lane = {{2{s[13]}}, s};
`endif
    return {lane, lane};
  endfunction

  function automatic int clampv(input int t, input int lo, input int hi);
    if (t < lo) return lo;
    if (t > hi) return hi;
    return t;
  endfunction

  function automatic int nextv(input int o, input int t, input int s);
    int d, a;
    d = t - o;
    a = (d < 0) ? -d : d;
    if (s == 0 || a <= s) return t;
    return (d > 0) ? o + s : o - s;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_out(input string tag, input int v);
    check(tag, M_AXIS_tdata_o, exp_tdata(v));
  endtask

  task automatic chk_st(input string tag, input logic [3:0] st);
    check(tag, {28'd0, status_o}, {28'd0, st});
  endtask

  task automatic load(input int t);
    target_i       = t[13:0];
    target_valid_i = 1'b1;
    tick();
    target_valid_i = 1'b0;
  endtask

  task automatic settle(input string tag, input int budget);
    int n;
    n = 0;
    while (status_o[0] !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    n_cmp++;
    assert (status_o[0] === 1'b1) else begin
      n_err++;
      $error("FAIL %s: at_target observed %0b expected 1 within %0d cycles", tag, status_o[0], budget);
    end
  endtask

  initial begin
    int lv, t, a, b, lo, hi;
    bit tv, rdy;
    rst_n           = 1'b0;
    en_i            = 1'b1;
    target_i        = '0;
    target_valid_i  = 1'b0;
    step_i          = 14'd100;
    lim_lo_i        = -14'sd8191;
    lim_hi_i        = 14'sd8191;
    M_AXIS_tready_i = 1'b1;

    tick();
    tick();
    check("rst_tvalid", {31'd0, M_AXIS_tvalid_o}, 32'd0);
    chk_out("rst_tdata", 0);
    chk_st("rst_status", 4'b0000);
    rst_n = 1'b1;
    repeat (4) tick();
    check("post_rst_tvalid", {31'd0, M_AXIS_tvalid_o}, 32'd1);
    chk_out("post_rst_tdata", 0);
    chk_st("post_rst_status", 4'b0000);

    // Basic ramp 0 -> 1000 in steps of 100.
    load(1000);
    chk_out("ramp_load_cycle", 0);
    chk_st("ramp_load_status", 4'b0010);
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk_out($sformatf("ramp_beat%0d", k), k * 100);
      chk_st($sformatf("ramp_status%0d", k), (k < 10) ? 4'b0010 : 4'b0001);
    end

    // Clamp to the upper limit, then an unclamped load clears the flag.
    lim_hi_i = 14'sd4000;
    step_i   = 14'd500;
    load(5000);
    settle("clamp_settle", 50);
    chk_out("clamp_out", 4000);
    chk_st("clamp_status", 4'b0101);
    load(3000);
    chk_st("unclamp_load_status", 4'b0010);
    settle("unclamp_settle", 50);
    chk_out("unclamp_out", 3000);
    chk_st("unclamp_status", 4'b0001);
    lim_hi_i = 14'sd8191;

    // Backpressure mid-ramp.
    step_i = 14'd0;
    load(0);
    settle("zero_settle", 10);
    chk_out("zero_out", 0);
    step_i = 14'd100;
    load(1000);
    repeat (5) tick();
    chk_out("bp_pre", 500);
    M_AXIS_tready_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk_out($sformatf("bp_hold%0d", k), 500);
    end
    chk_st("bp_status", 4'b0010);
    M_AXIS_tready_i = 1'b1;
    tick();
    chk_out("bp_resume", 600);
    settle("bp_settle", 20);
    chk_out("bp_final", 1000);

    // Disable ramps down to zero, then loads are ignored.
    step_i = 14'd300;
    en_i   = 1'b0;
    tick();
    chk_out("down_enter", 1000);
    chk_st("down_status", 4'b0010);
    lv = 1000;
    for (int k = 0; k < 4; k++) begin
      tick();
      lv = nextv(lv, 0, 300);
      chk_out($sformatf("down_beat%0d", k), lv);
    end
    chk_st("down_idle_status", 4'b0000);
    load(2000);
    repeat (3) tick();
    chk_out("idle_ignore_out", 0);
    chk_st("idle_ignore_status", 4'b0000);

    // Inverted limits force a fault; a valid load recovers.
    en_i   = 1'b1;
    step_i = 14'd100;
    load(1000);
    tick();
    tick();
    chk_out("fault_pre", 200);
    lim_lo_i = 14'sd10;
    lim_hi_i = -14'sd10;
    tick();
    chk_out("fault_out", 0);
    chk_st("fault_status", 4'b1000);
    lim_lo_i = -14'sd8191;
    lim_hi_i = 14'sd8191;
    tick();
    chk_st("fault_sticky", 4'b1000);
    step_i = 14'd0;
    load(50);
    chk_st("fault_exit_status", 4'b0010);
    tick();
    chk_out("fault_exit_out", 50);
    chk_st("fault_exit_hold", 4'b0001);

    // Randomized loads, limits, steps and backpressure against the model.
    m_out = 50; m_tgt = 50; m_step = 0; m_clamped = 0; m_settled = 1;
    for (int c = 0; c < 300; c++) begin
      tv  = ($urandom_range(11) == 0);
      rdy = ($urandom_range(3) != 0);
      if (tv) begin
        t  = int'($urandom_range(16383)) - 8192;
        a  = int'($urandom_range(16382)) - 8191;
        b  = int'($urandom_range(16382)) - 8191;
        lo = (a < b) ? a : b;
        hi = (a < b) ? b : a;
        m_step = ($urandom_range(4) == 0) ? 0 : int'($urandom_range(2000));
        lim_lo_i = lo[13:0];
        lim_hi_i = hi[13:0];
        step_i   = m_step[13:0];
        target_i = t[13:0];
      end
      target_valid_i  = tv;
      M_AXIS_tready_i = rdy;
      tick();
      target_valid_i = 1'b0;
      if (tv) begin
        m_tgt     = clampv(t, lo, hi);
        m_clamped = (m_tgt != t);
        m_settled = 0;
      end else if (rdy && !m_settled) begin
        m_out     = nextv(m_out, m_tgt, m_step);
        m_settled = (m_out == m_tgt);
      end
      chk_out($sformatf("rnd_out%0d", c), m_out);
      chk_st($sformatf("rnd_st%0d", c), {1'b0, m_clamped, !m_settled, m_settled});
    end
    M_AXIS_tready_i = 1'b1;
    lim_lo_i = -14'sd8191;
    lim_hi_i = 14'sd8191;

    // Asynchronous reset mid-ramp at -300.
    step_i = 14'd0;
    load(0);
    tick();
    chk_out("neg_zero", 0);
    step_i = 14'd100;
    load(-1000);
    repeat (3) tick();
    chk_out("neg_ramp", -300);
    rst_n = 1'b0;
    #1;
    chk_out("async_rst_tdata", 0);
    check("async_rst_tvalid", {31'd0, M_AXIS_tvalid_o}, 32'd0);
    chk_st("async_rst_status", 4'b0000);
    tick();
    rst_n = 1'b1;
    repeat (5) tick();
    chk_out("rst_release_out", 0);
    chk_st("rst_release_status", 4'b0000);
    check("rst_release_tvalid", {31'd0, M_AXIS_tvalid_o}, 32'd1);
    repeat (5) tick();
    chk_out("rst_no_resume", 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dac_slew_stage.md
DAC_SLEW_STAGE -- requirements
Module: dac_slew_stage

Interface
REQ-001 SHALL have parameter DAC_DATA_WIDTH, default 14, the DAC sample width (two's complement).
REQ-002 SHALL have parameter AXIS_TDATA_WIDTH, default 32, carrying two 16-bit DAC lanes.
REQ-003 SHALL have one clock and an asynchronous, active-low reset:
- clk  input  1  FCLK_CLK0 (125 MHz); all logic on the rising edge.
- rst_n  input  1  asynchronous assert, active-low.
REQ-004 SHALL have these ports:
- en_i  input  1  stage enable.
- target_i  input  14  signed setpoint from the core.
- target_valid_i  input  1  single-cycle target load strobe.
- step_i  input  14  unsigned maximum change per accepted beat; 0 means unlimited.
- lim_lo_i / lim_hi_i  input  14 each  signed clamp limits.
- M_AXIS_tdata_o  output  32  [15:0] and [31:16] both carry the output sample, sign-extended.
- M_AXIS_tvalid_o  output  1  sample valid.
- M_AXIS_tready_i  input  1  DAC accepts sample.
- status_o  output  4  {fault, clamped, ramping, at_target}.

Function
REQ-005 SHALL implement states IDLE, RAMP, HOLD and FAULT.
REQ-006 On target_valid_i with en_i high, SHALL latch target_i clamped to [lim_lo_i, lim_hi_i] and enter RAMP the next cycle.
REQ-007 SHALL set clamped when the latched target differed from target_i, and hold it until the next load.
REQ-008 SHALL advance the output register only on an accepted beat (tvalid && tready); when tready is low, output and state SHALL hold.
REQ-009 On each accepted beat in RAMP, SHALL compute diff = target − out at 15-bit signed width.
- If |diff| <= step_i or step_i == 0: out = target, and the state goes to HOLD.
- Otherwise: out = out ± step_i toward target, with no overshoot and no wrap.
REQ-010 A target load during RAMP or HOLD SHALL retarget from the current output without a glitch.
REQ-011 When en_i goes low from RAMP or HOLD, SHALL ramp toward 0 at step_i, then enter IDLE.
REQ-012 In IDLE, the output SHALL stay 0, and target loads SHALL be ignored while en_i is low.
REQ-013 If lim_lo_i > lim_hi_i at any cycle, SHALL force the output to 0 and enter FAULT the next cycle.
REQ-014 SHALL leave FAULT only on a target load with valid limits and en_i high.
REQ-015 M_AXIS_tvalid_o SHALL be high in every state from the first cycle after reset release.
REQ-016 tdata SHALL be the registered output, with zero combinational path from inputs.
REQ-017 status bits SHALL be asserted as follows:
- at_target: output equals target in HOLD.
- ramping: in RAMP or in the en_i-low ramp-down.
- fault: in FAULT.
REQ-018 A simultaneous target load and en_i fall SHALL give priority to en_i fall, and the load is dropped.

Reset
REQ-019 While rst_n is low, SHALL set: output 0, target 0, tvalid 0, status 0, state IDLE.
REQ-020 Reset asserted mid-ramp SHALL take effect immediately (asynchronous), and the ramp SHALL NOT resume after release.
REQ-021 Reset release SHALL be synchronised internally with a two-flop deassert synchroniser.

Configuration
REQ-022 Macro DAC_SLEW_OFFSET_BINARY_EN selects the lane encoding:
- Defined: each 16-bit lane SHALL carry offset-binary (MSB of the 14-bit sample inverted, zero-extended).
- Undefined: lanes SHALL carry two's complement, sign-extended.
- Internal arithmetic and status SHALL be identical either way.

Verification
REQ-023 step=100, limits ±8191, tready=1, load target=1000 from 0: output takes 0,100,...,900 then 1000; at_target is set after the 10th beat.
REQ-024 load target=5000 with lim_hi=4000: output settles at 4000 and clamped=1; a subsequent load of 3000 clears clamped.
REQ-025 Mid-ramp at out=500 toward 1000 (step 100), drop tready for 5 cycles: tdata holds 500; after release the sequence continues at 600.
REQ-026 At HOLD 1000 with step 300, drop en_i: output goes 700,400,100,0, then the state is IDLE; loads are ignored while en_i=0.
REQ-027 Set lim_lo=10, lim_hi=-10 during RAMP: output is 0 and fault=1 the next cycle; fix the limits and load 50 with step 0: output is 50 and fault clears.
REQ-028 Assert rst_n low mid-ramp at out=-300: tdata and tvalid are 0 immediately; after release the output stays 0 in IDLE.
